// File: rtl/dma_arbiter.sv
// dma_arbiter: memory-to-memory block-copy engine for the 65C02 SoC bus.
//
// While it owns the bus it holds the CPU with cpu_rdy=0. The top-level mux
// selects dma_addr/dma_we/dma_do whenever bus_grant=1. Each byte takes
// RD (present SRC), LATCH (synchronous read data arrives), WR (write to DST),
// so a byte costs 3 clk plus 1 clk of grant overhead per bus tenure.
//
// Register map (rs):
//   0 SRC_L, 1 SRC_H, 2 DST_L, 3 DST_H, 4 LEN_L, 5 LEN_H
//   6 CTRL   write: bit0 START, bit1 IE, bit2 INC_SRC, bit3 ABORT
//            read : {4'b0, 1'b0, INC_SRC, IE, 1'b0}
//   7 STATUS read : {5'b0, ABORTED, DONE, BUSY}; a read clears DONE/ABORTED
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cs, we, rs        register select, write strobe, register index
//   data_in/data_out  CPU write data / combinational register read data
//   bus_di            read data returned by the shared bus mux
//   cpu_rdy           0 stalls the CPU
//   bus_grant         1 = DMA drives dma_addr/dma_we/dma_do onto the bus
//   irq_n             active-low completion interrupt
//
// Optional feature: define DMA_IRQ_EN to drive irq_n low while DONE and IE are
// both set. Without it irq_n is tied high and IE is only stored.

module dma_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned BURST  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [2:0]        rs,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic [7:0]        bus_di,
  output logic              cpu_rdy,
  output logic              bus_grant,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_we,
  output logic [7:0]        dma_do,
  output logic              irq_n
);

  localparam int unsigned BurstW = (BURST > 0) ? $clog2(BURST + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StRd,
    StLatch,
    StWr,
    StYield,
    StFinish
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [BurstW-1:0] burst_q;
  logic              ie_q;
  logic              inc_src_q;
  logic              busy_q;
  logic              done_q;
  logic              aborted_q;
  logic              abort_pend_q;

  logic              reg_wr;
  logic              sts_rd;
  logic [15:0]       src16;
  logic [15:0]       dst16;
  logic [15:0]       len16;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic [BurstW-1:0] burst_nxt;
  logic              burst_end;

  always_comb begin
    reg_wr    = cs & we;
    sts_rd    = cs & ~we & (rs == 3'd7);
    // 16-bit views for the byte-wide register window
    src16     = 16'(src_q);
    dst16     = 16'(dst_q);
    len16     = 16'(len_q);
    src_nxt   = inc_src_q ? (src_q + ADDR_W'(1)) : src_q;
    dst_nxt   = dst_q + ADDR_W'(1);
    burst_nxt = burst_q + BurstW'(1);
    burst_end = (BURST != 0) && (burst_nxt == BurstW'(BURST));
  end

  always_comb begin
    data_out = 8'h00;
    case (rs)
      3'd0: data_out = src16[7:0];
      3'd1: data_out = src16[15:8];
      3'd2: data_out = dst16[7:0];
      3'd3: data_out = dst16[15:8];
      3'd4: data_out = len16[7:0];
      3'd5: data_out = len16[15:8];
      3'd6: data_out = {5'b00000, inc_src_q, ie_q, 1'b0};
      3'd7: data_out = {5'b00000, aborted_q, done_q, busy_q};
    endcase
  end

`ifdef DMA_IRQ_EN
  assign irq_n = ~(done_q & ie_q);
`else
  assign irq_n = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      ie_q         <= 1'b0;
      inc_src_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      cpu_rdy      <= 1'b1;
      bus_grant    <= 1'b0;
      dma_addr     <= '0;
      dma_we       <= 1'b0;
      dma_do       <= 8'h00;
    end else begin
      if (sts_rd) begin
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end

      // ABORT is only latched here; it is acted on at the next GRANT
      if (reg_wr && busy_q && (rs == 3'd6) && data_in[3]) begin
        abort_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: ;
        StGrant: begin
          if (abort_pend_q) begin
            state_q      <= StIdle;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b1;
            cpu_rdy      <= 1'b1;
          end else begin
            state_q   <= StRd;
            bus_grant <= 1'b1;
            dma_addr  <= src_q;
          end
        end
        StRd: state_q <= StLatch;
        StLatch: begin
          state_q  <= StWr;
          dma_do   <= bus_di;
          dma_addr <= dst_q;
          dma_we   <= 1'b1;
        end
        StWr: begin
          dma_we  <= 1'b0;
          src_q   <= src_nxt;
          dst_q   <= dst_nxt;
          len_q   <= len_q - LEN_W'(1);
          burst_q <= burst_nxt;
          if (len_q == LEN_W'(1)) begin
            state_q   <= StFinish;
            cpu_rdy   <= 1'b1;
            bus_grant <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (burst_end) begin
            state_q   <= StYield;
            cpu_rdy   <= 1'b1;
            bus_grant <= 1'b0;
            burst_q   <= '0;
          end else begin
            state_q  <= StRd;
            dma_addr <= src_nxt;
          end
        end
        StYield: begin
          state_q <= StGrant;
          cpu_rdy <= 1'b0;
        end
        StFinish: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Programming is locked out while a transfer is in flight
      if (reg_wr && !busy_q) begin
        case (rs)
          3'd0: src_q <= ADDR_W'({src16[15:8], data_in});
          3'd1: src_q <= ADDR_W'({data_in, src16[7:0]});
          3'd2: dst_q <= ADDR_W'({dst16[15:8], data_in});
          3'd3: dst_q <= ADDR_W'({data_in, dst16[7:0]});
          3'd4: len_q <= LEN_W'({len16[15:8], data_in});
          3'd5: len_q <= LEN_W'({data_in, len16[7:0]});
          3'd6: begin
            ie_q      <= data_in[1];
            inc_src_q <= data_in[2];
            if (data_in[0]) begin
              if (len_q == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= StGrant;
                busy_q  <= 1'b1;
                cpu_rdy <= 1'b0;
                burst_q <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// tb_dma_arbiter: directed bench for dma_arbiter. Two instances share one
// synchronous-read memory model: u_dut0 with BURST=0 and u_dut1 with BURST=2.
module tb_dma_arbiter;

  logic        clk;
  logic        reset;
  logic        cs0, cs1, we;
  logic [2:0]  rs;
  logic [7:0]  data_in;
  logic [7:0]  do_reg0, do_reg1;
  logic [7:0]  bus_rd;
  logic        rdy0, rdy1, grant0, grant1, dwe0, dwe1, irq0, irq1;
  logic [15:0] addr0, addr1;
  logic [7:0]  bdo0, bdo1;

  logic [15:0] bus_addr;
  logic        bus_we;
  logic [7:0]  bus_do;

  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  mem [0:65535];
  logic [15:0] wlog_addr [0:63];
  logic [7:0]  wlog_data [0:63];
  int          wlog_n;

  int n_vec;
  int n_err;
  int yield_at [0:3];

  dma_arbiter #(.ADDR_W(16), .LEN_W(16), .BURST(0)) u_dut0 (
    .clk(clk), .reset(reset), .cs(cs0), .we(we), .rs(rs), .data_in(data_in),
    .data_out(do_reg0), .bus_di(bus_rd), .cpu_rdy(rdy0), .bus_grant(grant0),
    .dma_addr(addr0), .dma_we(dwe0), .dma_do(bdo0), .irq_n(irq0)
  );

  dma_arbiter #(.ADDR_W(16), .LEN_W(16), .BURST(2)) u_dut1 (
    .clk(clk), .reset(reset), .cs(cs1), .we(we), .rs(rs), .data_in(data_in),
    .data_out(do_reg1), .bus_di(bus_rd), .cpu_rdy(rdy1), .bus_grant(grant1),
    .dma_addr(addr1), .dma_we(dwe1), .dma_do(bdo1), .irq_n(irq1)
  );

  assign bus_addr = grant0 ? addr0 : addr1;
  assign bus_we   = (grant0 & dwe0) | (grant1 & dwe1);
  assign bus_do   = grant0 ? bdo0 : bdo1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wlog_n = 0;
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus_we) begin
      mem[bus_addr] <= bus_do;
      if (wlog_n < 64) begin
        wlog_addr[wlog_n] <= bus_addr;
        wlog_data[wlog_n] <= bus_do;
      end
      wlog_n <= wlog_n + 1;
    end
    bus_rd <= mem[bus_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mem_load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic reg_wr(input int d, input logic [2:0] r, input logic [7:0] v);
    @(negedge clk);
    cs0 = (d == 0); cs1 = (d == 1); we = 1'b1; rs = r; data_in = v;
    @(negedge clk);
    cs0 = 1'b0; cs1 = 1'b0; we = 1'b0;
  endtask

  // Read with side effects (STATUS read clears DONE/ABORTED)
  task automatic reg_rd(input int d, input logic [2:0] r, output logic [7:0] v);
    @(negedge clk);
    cs0 = (d == 0); cs1 = (d == 1); we = 1'b0; rs = r;
    #1 v = (d == 0) ? do_reg0 : do_reg1;
    @(negedge clk);
    cs0 = 1'b0; cs1 = 1'b0;
  endtask

  // Side-effect-free look at a register (cs stays low)
  task automatic peek(input int d, input logic [2:0] r, output logic [7:0] v);
    rs = r;
    #1 v = (d == 0) ? do_reg0 : do_reg1;
  endtask

  task automatic setup(input int d, input logic [15:0] s, input logic [15:0] t,
                       input logic [15:0] l);
    reg_wr(d, 3'd0, s[7:0]);
    reg_wr(d, 3'd1, s[15:8]);
    reg_wr(d, 3'd2, t[7:0]);
    reg_wr(d, 3'd3, t[15:8]);
    reg_wr(d, 3'd4, l[7:0]);
    reg_wr(d, 3'd5, l[15:8]);
  endtask

  // Samples each negedge until BUSY drops; counts stalled and yield cycles
  task automatic wait_done(input int d, output int lows, output int yields);
    logic [7:0] st;
    logic       rdy;
    bit         fin;
    lows = 0; yields = 0; fin = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      peek(d, 3'd7, st);
      rdy = (d == 0) ? rdy0 : rdy1;
      if (!st[0]) fin = 1;
      else if (!rdy) lows++;
      else begin
        if (yields < 4) yield_at[yields] = wlog_n;
        yields++;
      end
      if (!fin) @(negedge clk);
    end
    check_eq("done_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    logic [7:0] v;
    int base, lows, yields;
    bit fin, ab;
    logic [7:0] src_bytes [0:4];
    src_bytes[0] = 8'h11; src_bytes[1] = 8'h22; src_bytes[2] = 8'h33;
    src_bytes[3] = 8'h44; src_bytes[4] = 8'h55;
    n_vec = 0; n_err = 0;
    reset = 1'b1; cs0 = 0; cs1 = 0; we = 0; rs = 0; data_in = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_rdy", 32'(rdy0), 32'd1);
    check_eq("rst_grant", 32'(grant0), 32'd0);
    check_eq("rst_irq", 32'(irq0), 32'd1);
    peek(0, 3'd7, v); check_eq("rst_status", 32'(v), 32'd0);

    for (int i = 0; i < 5; i++) mem_load(16'h0100 + 16'(i), src_bytes[i]);
    mem_load(16'h8000, 8'hA5);

    // 4-byte copy, no bursting
    setup(0, 16'h0100, 16'h0200, 16'd4);
    base = wlog_n;
    reg_wr(0, 3'd6, 8'h05);
    wait_done(0, lows, yields);
    check_eq("copy_stall", 32'(lows), 32'd13);
    check_eq("copy_nwr", 32'(wlog_n - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("copy_addr", 32'(wlog_addr[base + i]), 32'h0200 + 32'(i));
      check_eq("copy_data", 32'(wlog_data[base + i]), 32'(src_bytes[i]));
    end
    peek(0, 3'd7, v); check_eq("copy_status", 32'(v), 32'h02);
    peek(0, 3'd4, v); check_eq("copy_len_l", 32'(v), 32'h00);
    peek(0, 3'd6, v); check_eq("copy_ctrl", 32'(v), 32'h04);
    reg_rd(0, 3'd7, v); check_eq("copy_strd", 32'(v), 32'h02);
    peek(0, 3'd7, v); check_eq("copy_clr", 32'(v), 32'h00);

    // Fill from a fixed ROM source
    setup(0, 16'h8000, 16'h0300, 16'd3);
    base = wlog_n;
    reg_wr(0, 3'd6, 8'h01);
    wait_done(0, lows, yields);
    check_eq("fill_stall", 32'(lows), 32'd10);
    check_eq("fill_nwr", 32'(wlog_n - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq("fill_addr", 32'(wlog_addr[base + i]), 32'h0300 + 32'(i));
      check_eq("fill_data", 32'(wlog_data[base + i]), 32'hA5);
    end
    peek(0, 3'd0, v); check_eq("fill_src_l", 32'(v), 32'h00);
    peek(0, 3'd1, v); check_eq("fill_src_h", 32'(v), 32'h80);
    reg_rd(0, 3'd7, v);

    // Zero-length start: DONE immediately, no bus cycle
    base = wlog_n;
    reg_wr(0, 3'd6, 8'h03);
    peek(0, 3'd7, v); check_eq("len0_status", 32'(v), 32'h02);
    check_eq("len0_grant", 32'(grant0), 32'd0);
`ifdef DMA_IRQ_EN
    check_eq("len0_irq", 32'(irq0), 32'd0);
`else
    check_eq("len0_irq", 32'(irq0), 32'd1);
`endif
    repeat (3) @(negedge clk);
    check_eq("len0_nwr", 32'(wlog_n - base), 32'd0);
    reg_rd(0, 3'd7, v); check_eq("len0_strd", 32'(v), 32'h02);
    peek(0, 3'd7, v); check_eq("len0_clr", 32'(v), 32'h00);
    check_eq("len0_irq_clr", 32'(irq0), 32'd1);

    // BURST=2, 5 bytes: bursts of 2, 2, 1
    setup(1, 16'h0100, 16'h0400, 16'd5);
    base = wlog_n;
    reg_wr(1, 3'd6, 8'h05);
    wait_done(1, lows, yields);
    check_eq("burst_stall", 32'(lows), 32'd18);
    check_eq("burst_yields", 32'(yields), 32'd2);
    check_eq("burst_y0", 32'(yield_at[0] - base), 32'd2);
    check_eq("burst_y1", 32'(yield_at[1] - base), 32'd4);
    check_eq("burst_nwr", 32'(wlog_n - base), 32'd5);
    check_eq("burst_last_a", 32'(wlog_addr[base + 4]), 32'h0404);
    check_eq("burst_last_d", 32'(wlog_data[base + 4]), 32'h55);
    reg_rd(1, 3'd7, v);

    // Destination wrap, then ABORT in the first yield window
    setup(1, 16'h0100, 16'hFFFF, 16'd4);
    base = wlog_n;
    reg_wr(1, 3'd6, 8'h05);
    fin = 0; ab = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      peek(1, 3'd7, v);
      if (!v[0]) fin = 1;
      else if (rdy1 && !ab) begin
        cs1 = 1'b1; we = 1'b1; rs = 3'd6; data_in = 8'h08; ab = 1;
        @(negedge clk);
        cs1 = 1'b0; we = 1'b0;
      end else @(negedge clk);
    end
    check_eq("abort_timeout", 32'(fin), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("abort_nwr", 32'(wlog_n - base), 32'd2);
    check_eq("wrap_a0", 32'(wlog_addr[base]), 32'hFFFF);
    check_eq("wrap_a1", 32'(wlog_addr[base + 1]), 32'h0000);
    check_eq("wrap_d1", 32'(wlog_data[base + 1]), 32'h22);
    peek(1, 3'd7, v); check_eq("abort_status", 32'(v), 32'h04);
    peek(1, 3'd2, v); check_eq("abort_dst_l", 32'(v), 32'h01);
    peek(1, 3'd3, v); check_eq("abort_dst_h", 32'(v), 32'h00);
    peek(1, 3'd4, v); check_eq("abort_len_l", 32'(v), 32'h02);
    peek(1, 3'd0, v); check_eq("abort_src_l", 32'(v), 32'h02);
    peek(1, 3'd6, v); check_eq("abort_ctrl", 32'(v), 32'h04);
    check_eq("abort_rdy", 32'(rdy1), 32'd1);

    // Asynchronous reset in the middle of a write
    setup(0, 16'h0100, 16'h0500, 16'd4);
    reg_wr(0, 3'd6, 8'h05);
    fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      if (dwe0) fin = 1;
      else @(negedge clk);
    end
    check_eq("midwr_seen", 32'(fin), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_rdy", 32'(rdy0), 32'd1);
    check_eq("arst_grant", 32'(grant0), 32'd0);
    check_eq("arst_we", 32'(dwe0), 32'd0);
    check_eq("arst_addr", 32'(addr0), 32'd0);
    for (int r = 0; r < 8; r++) begin
      peek(0, 3'(r), v);
      check_eq("arst_reg", 32'(v), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_rst_rdy", 32'(rdy0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
